// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth calculation.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

    localparam int unsigned PTR_W_MAX = 32;

    // Zero-extended operands convert correctly at any width up to PTR_W_MAX.
    function automatic logic [PTR_W_MAX-1:0] bin2gray(
        input logic [PTR_W_MAX-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_W_MAX-1:0] gray2bin(
        input logic [PTR_W_MAX-1:0] g
    );
        logic [PTR_W_MAX-1:0] b;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned FIFO_DEPTH(input int unsigned ptr_size);
        return 32'd1 << (ptr_size - 1);
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the parity
// of all Gray bits at or above it.
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side pointer/status controller (read clock domain).
// Optional occupancy and almost-empty unit enabled by FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int Pointer_Size     = 4,
    parameter int Almost_Empty_Thr = 2
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    rinc,
    input  logic [Pointer_Size-1:0] sync_w2r_ptr,
    output logic [Pointer_Size-1:0] gray_r2w_ptr,
    output logic [Pointer_Size-2:0] raddr,
    output logic                    rempty,
    output logic                    runderflow,
    output logic [Pointer_Size-1:0] rd_level,
    output logic                    ralmost_empty
);

    logic [Pointer_Size-1:0] rptr;
    logic [Pointer_Size-1:0] rptr_next;
    logic [Pointer_Size-1:0] rgray_next;
    logic                    rd_en;

    assign rd_en      = rinc & ~rempty;
    assign rptr_next  = rptr + Pointer_Size'(rd_en);
    assign rgray_next = Pointer_Size'(bin2gray(PTR_W_MAX'(rptr_next)));
    assign raddr      = rptr[Pointer_Size-2:0];

    // Empty uses the next Gray value so the last read flags empty at once.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rptr         <= '0;
            gray_r2w_ptr <= '0;
            rempty       <= 1'b1;
            runderflow   <= 1'b0;
        end else begin
            rptr         <= rptr_next;
            gray_r2w_ptr <= rgray_next;
            rempty       <= (rgray_next == sync_w2r_ptr);
            runderflow   <= runderflow | (rinc & rempty);
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [Pointer_Size-1:0] wbin;
    logic [Pointer_Size-1:0] level_next;

    fifo_gray2bin #(
        .W (Pointer_Size)
    ) u_gray2bin (
        .gray (sync_w2r_ptr),
        .bin  (wbin)
    );

    // Modulo subtract keeps the level correct across pointer wrap.
    assign level_next = wbin - rptr_next;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rd_level      <= '0;
            ralmost_empty <= 1'b1;
        end else begin
            rd_level      <= level_next;
            ralmost_empty <= (int'(level_next) <= Almost_Empty_Thr);
        end
    end
`else
    assign rd_level      = '0;
    assign ralmost_empty = rempty;
`endif

endmodule
